lsu_load_unit: RTL and testbench
================================

// Module: lsu_load_unit
// PURPOSE
//  Load path of the LSU: accepts one load request (address + readop), issues one read on the
//  data-bus AR/R channels, then extracts, sign/zero-extends and returns the result to WBU.
//  Parametrised in XLEN (32/64) and fully handshaked on all three sides.
//  Holds one request at a time; sits between EXU/LSU control and the data-memory bus.
// PARAMETERS
//  XLEN    32  datapath and bus data width, 32 or 64; BYTES = XLEN/8
//  ADDR_W  32  byte-address width
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       synchronous reset, active-high
//  req_valid  in   1       load request valid
//  req_ready  out  1       load request accepted when both high
//  req_addr   in   ADDR_W  byte address
//  req_op     in   3       0 LB,1 LH,2 LW,3 LD,4 LBU,5 LHU,6 LWU (funct3 encoding)
//  ar_valid   out  1       bus read-address valid
//  ar_ready   in   1       bus read-address ready
//  ar_addr    out  ADDR_W  bus address, aligned down to BYTES
//  r_valid    in   1       bus read-data valid
//  r_ready    out  1       bus read-data ready
//  r_data     in   XLEN    bus read data, byte 0 at bits [7:0]
//  r_resp     in   2       bus response, 0 = OKAY, nonzero = error
//  rsp_valid  out  1       load result valid
//  rsp_ready  in   1       load result consumed when both high
//  rsp_data   out  XLEN    extended load result
//  rsp_err    out  1       access fault / misalign / illegal op
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1, ar_valid=0, r_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
//    rst mid-transaction abandons it; outputs take reset values after that edge.
//  - FSM: IDLE -> AR -> R -> RESP -> IDLE. req_ready=1 only in IDLE.
//  - IDLE: on req handshake latch off=addr[log2(BYTES)-1:0], aligned addr, op. Illegal op
//    (3 or 6 when XLEN=32; 7 always) or misaligned access -> RESP, err=1, data=0, no bus access.
//  - Misaligned: off+size > BYTES (size 1/2/4/8 for B/H/W/D). Naturally aligned never is.
//  - AR: ar_valid=1, ar_addr stable until ar_ready; then R.
//  - R: r_ready=1; on r_valid capture r_data; r_resp!=0 -> err=1, data=0; then RESP.
//  - RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready; then IDLE.
//  - Extract: field = r_data >> (off*8), width by op; signed ops replicate field MSB to XLEN.
//  - Min latency (ar_ready, r_valid, rsp_ready all high): req accepted edge 0, ar edge 1,
//    r edge 2, rsp_valid high in cycle 3; new req accepted cycle 4. Max 1 in flight.
//  - r_valid outside R is ignored (r_ready=0); ar_ready outside AR is ignored.
// CONFIGURATION
//  LSU_LOAD_MISALIGN_EN defined: misaligned loads are split, not faulted. FSM adds
//    AR2/R2 after R: second beat at aligned addr+BYTES (wraps mod 2^ADDR_W); merged
//    {beat2,beat1} >> (off*8), then extended; err if either r_resp nonzero (both beats
//    always issued). Min latency 5 cycles to rsp_valid.
//  Not defined: misaligned loads return rsp_err=1, rsp_data=0 with no bus access, in cycle 1.
// TESTING
//  XLEN=32, LB addr 0x..3, r_data=0x80FF_0000 -> rsp_data 0xFFFF_FF80, err 0
//  LHU addr 0x..2, r_data=0xBEEF_1234 -> rsp_data 0x0000_BEEF; LW addr 0x..0 -> r_data as is
//  XLEN=64, LWU addr 0x..4, r_data=0xDEAD_BEEF_0000_0000 -> 0x0000_0000_DEAD_BEEF;
//    LD on XLEN=32 -> err 1, ar_valid never asserted
//  ar_ready low 3 cycles, r_valid low 2, rsp_ready low 2 -> ar_addr/rsp_data held stable,
//    r_resp=2 -> rsp_err 1, data 0
//  LW addr 0x..2: without macro -> err 1 in cycle 1; with macro, beats 0x5566_7788 and
//    0x1122_3344 at 0x..0/0x..4 -> rsp_data 0x3344_5566, two AR handshakes
//  rst asserted in R state with r_valid high -> next cycle IDLE, rsp_valid 0, req_ready 1

Source files
------------

// File: rtl/lsu_load_unit.sv
// Load path of the LSU: one load request -> one (or two, when split) bus reads -> extended result.
// Optional macro LSU_LOAD_MISALIGN_EN splits misaligned loads into two aligned beats.
module lsu_load_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [2:0]        i_req_op,
  output logic              o_ar_valid,
  input  logic              i_ar_ready,
  output logic [ADDR_W-1:0] o_ar_addr,
  input  logic              i_r_valid,
  output logic              o_r_ready,
  input  logic [XLEN-1:0]   i_r_data,
  input  logic [1:0]        i_r_resp,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [XLEN-1:0]   o_rsp_data,
  output logic              o_rsp_err
);

  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StAr2,
    StR2,
    StResp
  } state_e;

  state_e              r_state;
  logic                r_req_ready;
  logic                r_ar_valid;
  logic                r_r_ready;
  logic                r_rsp_valid;
  logic [XLEN-1:0]     r_rsp_data;
  logic                r_rsp_err;
  logic [OFF_W-1:0]    r_off;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_ar_addr;
`ifdef LSU_LOAD_MISALIGN_EN
  logic                r_split;
  logic [XLEN-1:0]     r_beat1;
  logic                r_err1;
`endif

  logic [OFF_W-1:0]    w_off;
  logic [ADDR_W-1:0]   w_aligned;
  logic [3:0]          w_size;
  logic [4:0]          w_end;
  logic                w_misalign;
  logic                w_illegal;
  logic                w_fault;
  logic                w_rerr;
  logic [2*XLEN-1:0]   w_raw;
  logic [XLEN-1:0]     w_ext;

  // Shift the (possibly two-beat) raw data down to the field, then sign/zero-extend.
  function automatic logic [XLEN-1:0] f_extract(input logic [2*XLEN-1:0] raw,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [2:0]        op);
    logic [63:0] sh;
    logic [63:0] res;
    logic        sx;
    sh = 64'(raw >> {off, 3'b000});
    sx = ~op[2];
    case (op[1:0])
      2'd0:    res = {{56{sx & sh[7]}}, sh[7:0]};
      2'd1:    res = {{48{sx & sh[15]}}, sh[15:0]};
      2'd2:    res = {{32{sx & sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return XLEN'(res);
  endfunction

  always_comb begin
    w_off     = i_req_addr[OFF_W-1:0];
    w_aligned = {i_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    case (i_req_op[1:0])
      2'd0:    w_size = 4'd1;
      2'd1:    w_size = 4'd2;
      2'd2:    w_size = 4'd4;
      default: w_size = 4'd8;
    endcase
    w_end      = 5'(w_off) + 5'(w_size);
    w_misalign = (w_end > 5'(BYTES));
    w_illegal  = (i_req_op == 3'd7) ||
                 ((XLEN == 32) && ((i_req_op == 3'd3) || (i_req_op == 3'd6)));
`ifdef LSU_LOAD_MISALIGN_EN
    w_fault    = w_illegal;
    w_raw      = (r_state == StR2) ? {i_r_data, r_beat1} : {{XLEN{1'b0}}, i_r_data};
`else
    w_fault    = w_illegal | w_misalign;
    w_raw      = {{XLEN{1'b0}}, i_r_data};
`endif
    w_rerr     = (i_r_resp != 2'b00);
    w_ext      = f_extract(w_raw, r_off, r_op);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b1;
      r_ar_valid  <= 1'b0;
      r_r_ready   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_off       <= '0;
      r_op        <= '0;
      r_ar_addr   <= '0;
`ifdef LSU_LOAD_MISALIGN_EN
      r_split     <= 1'b0;
      r_beat1     <= '0;
      r_err1      <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (i_req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_off       <= w_off;
            r_op        <= i_req_op;
            r_ar_addr   <= w_aligned;
`ifdef LSU_LOAD_MISALIGN_EN
            r_split     <= w_misalign;
`endif
            if (w_fault) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_state     <= StResp;
            end else begin
              r_ar_valid  <= 1'b1;
              r_state     <= StAr;
            end
          end
        end
        StAr: begin
          if (i_ar_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= StR;
          end
        end
        StR: begin
          if (i_r_valid) begin
            r_r_ready <= 1'b0;
`ifdef LSU_LOAD_MISALIGN_EN
            if (r_split) begin
              r_beat1    <= i_r_data;
              r_err1     <= w_rerr;
              r_ar_valid <= 1'b1;
              r_ar_addr  <= r_ar_addr + ADDR_W'(BYTES);
              r_state    <= StAr2;
            end else
`endif
            begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_rerr;
              r_rsp_data  <= w_rerr ? '0 : w_ext;
              r_state     <= StResp;
            end
          end
        end
`ifdef LSU_LOAD_MISALIGN_EN
        StAr2: begin
          if (i_ar_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= StR2;
          end
        end
        StR2: begin
          if (i_r_valid) begin
            r_r_ready   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err1 | w_rerr;
            r_rsp_data  <= (r_err1 | w_rerr) ? '0 : w_ext;
            r_state     <= StResp;
          end
        end
`endif
        StResp: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_req_ready <= 1'b1;
          r_ar_valid  <= 1'b0;
          r_r_ready   <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_ar_valid  = r_ar_valid;
  assign o_ar_addr   = r_ar_addr;
  assign o_r_ready   = r_r_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_load_unit.sv
// Bench for lsu_load_unit: XLEN=32 and XLEN=64 instances share one bus/response driver.
// Expected values follow LSU_LOAD_MISALIGN_EN when it is defined for the build.
module tb_lsu_load_unit;

`ifdef LSU_LOAD_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        sel64;
  logic        req_valid32, req_valid64;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic        ar_ready;
  logic        r_valid;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        rsp_ready;

  logic        req_ready32, ar_valid32, r_ready32, rsp_valid32, rsp_err32;
  logic [31:0] ar_addr32, rsp_data32;
  logic        req_ready64, ar_valid64, r_ready64, rsp_valid64, rsp_err64;
  logic [31:0] ar_addr64;
  logic [63:0] rsp_data64;

  logic        m_req_ready, m_ar_valid, m_r_ready, m_rsp_valid, m_rsp_err;
  logic [31:0] m_ar_addr;
  logic [63:0] m_rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  lsu_load_unit #(.XLEN(32), .ADDR_W(32)) u_dut32 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid32), .o_req_ready(req_ready32),
    .i_req_addr(req_addr), .i_req_op(req_op),
    .o_ar_valid(ar_valid32), .i_ar_ready(ar_ready), .o_ar_addr(ar_addr32),
    .i_r_valid(r_valid), .o_r_ready(r_ready32), .i_r_data(r_data[31:0]), .i_r_resp(r_resp),
    .o_rsp_valid(rsp_valid32), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data32), .o_rsp_err(rsp_err32)
  );

  lsu_load_unit #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid64), .o_req_ready(req_ready64),
    .i_req_addr(req_addr), .i_req_op(req_op),
    .o_ar_valid(ar_valid64), .i_ar_ready(ar_ready), .o_ar_addr(ar_addr64),
    .i_r_valid(r_valid), .o_r_ready(r_ready64), .i_r_data(r_data), .i_r_resp(r_resp),
    .o_rsp_valid(rsp_valid64), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data64), .o_rsp_err(rsp_err64)
  );

  assign m_req_ready = sel64 ? req_ready64 : req_ready32;
  assign m_ar_valid  = sel64 ? ar_valid64  : ar_valid32;
  assign m_ar_addr   = sel64 ? ar_addr64   : ar_addr32;
  assign m_r_ready   = sel64 ? r_ready64   : r_ready32;
  assign m_rsp_valid = sel64 ? rsp_valid64 : rsp_valid32;
  assign m_rsp_err   = sel64 ? rsp_err64   : rsp_err32;
  assign m_rsp_data  = sel64 ? rsp_data64  : {32'h0, rsp_data32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one load and acts as bus slave / response sink with the given stall counts.
  task automatic run_load(input string name, input bit s64, input logic [31:0] addr,
                          input logic [2:0] op, input logic [63:0] d1, input logic [63:0] d2,
                          input logic [1:0] resp, input int ard, input int rd, input int rspd,
                          input logic [63:0] exp_data, input bit exp_err, input int exp_nar,
                          input int exp_lat, input logic [31:0] exp_a1,
                          input logic [31:0] exp_a2);
    int nar = 0, nr = 0, lat = 0, arw = 0, rw = 0, rspw = 0;
    bit done = 0, ar_pend = 0, rsp_seen = 0, ar_stable = 1, rsp_stable = 1;
    logic [31:0] a1 = '0, a2 = '0, a_hold = '0;
    logic [63:0] d_hold = '0, got_data = '0;
    logic        e_hold = 1'b0;
    sel64 = s64;
    @(negedge clk);
    chk({name, " req_ready idle"}, 64'(m_req_ready), 64'd1);
    req_addr = addr;
    req_op   = op;
    if (s64) req_valid64 = 1'b1;
    else     req_valid32 = 1'b1;
    @(posedge clk);
    #1;
    req_valid32 = 1'b0;
    req_valid64 = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      if (c == 1) chk({name, " req_ready busy"}, 64'(m_req_ready), 64'd0);
      ar_ready  = 1'b0;
      r_valid   = 1'b0;
      rsp_ready = 1'b0;
      if (m_ar_valid) begin
        if (ar_pend && (m_ar_addr != a_hold)) ar_stable = 0;
        a_hold  = m_ar_addr;
        ar_pend = 1;
        if (arw >= ard) begin
          ar_ready = 1'b1;
          if (nar == 0) a1 = m_ar_addr;
          else          a2 = m_ar_addr;
          nar++;
          arw     = 0;
          ar_pend = 0;
        end else arw++;
      end
      if (m_r_ready) begin
        if (rw >= rd) begin
          r_valid = 1'b1;
          r_data  = (nr == 0) ? d1 : d2;
          r_resp  = resp;
          nr++;
          rw = 0;
        end else rw++;
      end
      if (m_rsp_valid) begin
        if (!rsp_seen) begin
          rsp_seen = 1;
          lat      = c;
          d_hold   = m_rsp_data;
          e_hold   = m_rsp_err;
        end else if ((m_rsp_data != d_hold) || (m_rsp_err != e_hold)) rsp_stable = 0;
        got_data = m_rsp_data;
        if (rspw >= rspd) begin
          rsp_ready = 1'b1;
          done      = 1;
        end else rspw++;
      end
    end
    @(posedge clk);
    #1;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    rsp_ready = 1'b0;
    r_resp    = 2'd0;
    chk({name, " completed"}, 64'(done), 64'd1);
    chk({name, " rsp_data"}, got_data, exp_data);
    chk({name, " rsp_err"}, 64'(e_hold), 64'(exp_err));
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " ar count"}, 64'(nar), 64'(exp_nar));
    if (exp_nar > 0) chk({name, " ar_addr"}, 64'(a1), 64'(exp_a1));
    if (exp_nar > 1) chk({name, " ar_addr beat2"}, 64'(a2), 64'(exp_a2));
    chk({name, " ar_addr stable"}, 64'(ar_stable), 64'd1);
    chk({name, " rsp stable"}, 64'(rsp_stable), 64'd1);
    @(negedge clk);
    chk({name, " req_ready after"}, 64'(m_req_ready), 64'd1);
    chk({name, " rsp_valid after"}, 64'(m_rsp_valid), 64'd0);
  endtask

  typedef struct {
    string       name;
    bit          s64;
    logic [31:0] addr;
    logic [2:0]  op;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [1:0]  resp;
    logic [63:0] exp_data;
    bit          exp_err;
    int          exp_nar;
    int          exp_lat;
    logic [31:0] a1;
    logic [31:0] a2;
  } vec_t;

  vec_t vecs[19];
  bit   got_r;

  initial begin
    vecs[0]  = '{"lb_32", 1'b0, 32'h1003, 3'd0, 64'h80FF_0000, 64'h0, 2'd0,
                 64'hFFFF_FF80, 1'b0, 1, 3, 32'h1000, 32'h0};
    vecs[1]  = '{"lhu_32", 1'b0, 32'h2002, 3'd5, 64'hBEEF_1234, 64'h0, 2'd0,
                 64'h0000_BEEF, 1'b0, 1, 3, 32'h2000, 32'h0};
    vecs[2]  = '{"lw_32", 1'b0, 32'h3000, 3'd2, 64'hCAFE_F00D, 64'h0, 2'd0,
                 64'hCAFE_F00D, 1'b0, 1, 3, 32'h3000, 32'h0};
    vecs[3]  = '{"lbu_32", 1'b0, 32'h4001, 3'd4, 64'h0000_9A00, 64'h0, 2'd0,
                 64'h0000_009A, 1'b0, 1, 3, 32'h4000, 32'h0};
    vecs[4]  = '{"lh_32", 1'b0, 32'h5002, 3'd1, 64'h8001_0000, 64'h0, 2'd0,
                 64'hFFFF_8001, 1'b0, 1, 3, 32'h5000, 32'h0};
    vecs[5]  = '{"ld_32", 1'b0, 32'h6000, 3'd3, 64'h1111_1111, 64'h0, 2'd0,
                 64'h0, 1'b1, 0, 1, 32'h0, 32'h0};
    vecs[6]  = '{"lwu_32", 1'b0, 32'h6004, 3'd6, 64'h1111_1111, 64'h0, 2'd0,
                 64'h0, 1'b1, 0, 1, 32'h0, 32'h0};
    vecs[7]  = '{"op7_32", 1'b0, 32'h6008, 3'd7, 64'h1111_1111, 64'h0, 2'd0,
                 64'h0, 1'b1, 0, 1, 32'h0, 32'h0};
    vecs[8]  = '{"lh_mis_32", 1'b0, 32'h7003, 3'd1, 64'hAB00_0000, 64'h0000_00CD, 2'd0,
                 MIS ? 64'hFFFF_CDAB : 64'h0, !MIS, MIS ? 2 : 0, MIS ? 5 : 1,
                 MIS ? 32'h7000 : 32'h0, MIS ? 32'h7004 : 32'h0};
    vecs[9]  = '{"lw_mis_32", 1'b0, 32'h8002, 3'd2, 64'h5566_7788, 64'h1122_3344, 2'd0,
                 MIS ? 64'h3344_5566 : 64'h0, !MIS, MIS ? 2 : 0, MIS ? 5 : 1,
                 MIS ? 32'h8000 : 32'h0, MIS ? 32'h8004 : 32'h0};
    vecs[10] = '{"lw_wrap_32", 1'b0, 32'hFFFF_FFFE, 3'd2, 64'h1234_0000, 64'h0000_5678, 2'd0,
                 MIS ? 64'h5678_1234 : 64'h0, !MIS, MIS ? 2 : 0, MIS ? 5 : 1,
                 MIS ? 32'hFFFF_FFFC : 32'h0, 32'h0};
    vecs[11] = '{"lw_rerr_32", 1'b0, 32'h9000, 3'd2, 64'hDEAD_BEEF, 64'h0, 2'd2,
                 64'h0, 1'b1, 1, 3, 32'h9000, 32'h0};
    vecs[12] = '{"lwu_64", 1'b1, 32'h0004, 3'd6, 64'hDEAD_BEEF_0000_0000, 64'h0, 2'd0,
                 64'h0000_0000_DEAD_BEEF, 1'b0, 1, 3, 32'h0, 32'h0};
    vecs[13] = '{"lw_64", 1'b1, 32'h1_0004, 3'd2, 64'hDEAD_BEEF_0000_0000, 64'h0, 2'd0,
                 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 1, 3, 32'h1_0000, 32'h0};
    vecs[14] = '{"ld_64", 1'b1, 32'h2_0000, 3'd3, 64'h0123_4567_89AB_CDEF, 64'h0, 2'd0,
                 64'h0123_4567_89AB_CDEF, 1'b0, 1, 3, 32'h2_0000, 32'h0};
    vecs[15] = '{"lb_64", 1'b1, 32'h3_0007, 3'd0, 64'h8000_0000_0000_0000, 64'h0, 2'd0,
                 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 3, 32'h3_0000, 32'h0};
    vecs[16] = '{"ld_mis_64", 1'b1, 32'h4_0004, 3'd3, 64'hAAAA_AAAA_0000_0000,
                 64'h0000_0000_BBBB_BBBB, 2'd0,
                 MIS ? 64'hBBBB_BBBB_AAAA_AAAA : 64'h0, !MIS, MIS ? 2 : 0, MIS ? 5 : 1,
                 MIS ? 32'h4_0000 : 32'h0, MIS ? 32'h4_0008 : 32'h0};
    vecs[17] = '{"op7_64", 1'b1, 32'h5_0000, 3'd7, 64'h1, 64'h0, 2'd0,
                 64'h0, 1'b1, 0, 1, 32'h0, 32'h0};
    vecs[18] = '{"lh_64", 1'b1, 32'h6_0006, 3'd1, 64'h7FFF_0000_0000_0000, 64'h0, 2'd0,
                 64'h0000_0000_0000_7FFF, 1'b0, 1, 3, 32'h6_0000, 32'h0};

    rst = 1'b1; sel64 = 1'b0; req_valid32 = 1'b0; req_valid64 = 1'b0;
    req_addr = '0; req_op = '0; ar_ready = 1'b0; r_valid = 1'b0; r_data = '0;
    r_resp = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset req_ready32", 64'(req_ready32), 64'd1);
    chk("reset ar_valid32", 64'(ar_valid32), 64'd0);
    chk("reset r_ready32", 64'(r_ready32), 64'd0);
    chk("reset rsp_valid32", 64'(rsp_valid32), 64'd0);
    chk("reset rsp_data32", 64'(rsp_data32), 64'd0);
    chk("reset rsp_err32", 64'(rsp_err32), 64'd0);
    chk("reset req_ready64", 64'(req_ready64), 64'd1);
    chk("reset rsp_valid64", 64'(rsp_valid64), 64'd0);
    chk("reset rsp_data64", rsp_data64, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      run_load(vecs[i].name, vecs[i].s64, vecs[i].addr, vecs[i].op, vecs[i].d1, vecs[i].d2,
               vecs[i].resp, 0, 0, 0, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_nar,
               vecs[i].exp_lat, vecs[i].a1, vecs[i].a2);
    end

    // Back-pressure on every channel, with a bus error response.
    run_load("bp_rerr_32", 1'b0, 32'hA000, 3'd2, 64'h1234_5678, 64'h0, 2'd2, 3, 2, 2,
             64'h0, 1'b1, 1, 8, 32'hA000, 32'h0);
    run_load("bp_lhu_32", 1'b0, 32'hA002, 3'd5, 64'hBEEF_1234, 64'h0, 2'd0, 1, 0, 3,
             64'h0000_BEEF, 1'b0, 1, 4, 32'hA000, 32'h0);
    run_load("bp_lb_64", 1'b1, 32'hA005, 3'd0, 64'h0000_7F00_0000_0000, 64'h0, 2'd0, 2, 1, 1,
             64'h0000_0000_0000_007F, 1'b0, 1, 6, 32'hA000, 32'h0);

    // Reset while waiting in R with r_valid high abandons the load.
    sel64 = 1'b0;
    got_r = 1'b0;
    @(negedge clk);
    req_addr = 32'h0000_B000; req_op = 3'd2; req_valid32 = 1'b1;
    @(posedge clk);
    #1 req_valid32 = 1'b0;
    for (int c = 0; c < 20 && !got_r; c++) begin
      @(negedge clk);
      ar_ready = m_ar_valid;
      if (m_r_ready) begin
        got_r   = 1'b1;
        r_valid = 1'b1;
        r_data  = 64'h1234_5678;
        rst     = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    ar_ready = 1'b0; r_valid = 1'b0; rst = 1'b0;
    chk("rst_mid_r reached R", 64'(got_r), 64'd1);
    @(negedge clk);
    chk("rst_mid_r req_ready", 64'(req_ready32), 64'd1);
    chk("rst_mid_r rsp_valid", 64'(rsp_valid32), 64'd0);
    chk("rst_mid_r r_ready", 64'(r_ready32), 64'd0);
    chk("rst_mid_r ar_valid", 64'(ar_valid32), 64'd0);
    @(negedge clk);
    chk("rst_mid_r rsp_valid later", 64'(rsp_valid32), 64'd0);
    run_load("after_rst_32", 1'b0, 32'hC001, 3'd0, 64'h0000_FE00, 64'h0, 2'd0, 0, 0, 0,
             64'hFFFF_FFFE, 1'b0, 1, 3, 32'hC000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
